// File: rtl/pwm_seq_pkg.sv
// pwm_seq_pkg: shared types and constants for the PWM sequencer
package pwm_seq_pkg;
    localparam int REPW = 8;
    localparam logic [1:0] SEL_NONE = 2'd0;
    localparam logic [1:0] SEL_CMP  = 2'd1;
    localparam logic [1:0] SEL_TOP  = 2'd2;
    localparam logic [1:0] SEL_CNT  = 2'd3;
    typedef enum logic [2:0] {IDLE, LD_CMP, LD_TOP, SYNC, RUN, PARK} state_t;
    typedef struct packed {
        logic [15:0]     cmp;
        logic [15:0]     top;
        logic [REPW-1:0] rep;
    } pwm_entry_t;
endpackage

// File: rtl/pwm_seq_ctrl_if.sv
// pwm_seq_ctrl_if: CPU-side table/control signals plus the PWM channel bus
interface pwm_seq_ctrl_if #(
    parameter int DEPTH = 8,
    parameter int AW    = $clog2(DEPTH)
);
    logic                        wr_en;
    logic [AW-1:0]               wr_addr;
    logic [15:0]                 wr_cmp;
    logic [15:0]                 wr_top;
    logic [pwm_seq_pkg::REPW-1:0] wr_rep;
    logic [AW:0]                 len;
    logic                        loop;
    logic                        start;
    logic                        stop;
    logic [15:0]                 pwm_cnt;
    logic [15:0]                 pwm_top;
    logic [15:0]                 pwm_d;
    logic [1:0]                  pwm_sel;
    logic                        busy;
    logic [AW-1:0]               idx;
    logic                        done;
    logic                        err;
    modport master (
        output wr_en, wr_addr, wr_cmp, wr_top, wr_rep, len, loop, start, stop, pwm_cnt, pwm_top,
        input  pwm_d, pwm_sel, busy, idx, done, err
    );
    modport slave (
        input  wr_en, wr_addr, wr_cmp, wr_top, wr_rep, len, loop, start, stop, pwm_cnt, pwm_top,
        output pwm_d, pwm_sel, busy, idx, done, err
    );
endinterface

// File: rtl/pwm_seq_table.sv
// pwm_seq_table: entry register file; writes with top < 2 are dropped and flagged
module pwm_seq_table
    import pwm_seq_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          nrst,
    input  logic          i_wr_en,
    input  logic [AW-1:0] i_wr_addr,
    input  pwm_entry_t    i_wr_ent,
    input  logic [AW-1:0] i_rd_addr,
    output pwm_entry_t    o_rd_ent,
    output logic          o_err
);
    pwm_entry_t r_tbl [DEPTH];
    logic       r_err;
    logic       w_ok;

    assign w_ok     = i_wr_ent.top >= 16'd2;
    assign o_rd_ent = r_tbl[i_rd_addr];
    assign o_err    = r_err;

    always_ff @(posedge clk or negedge nrst)
        if (!nrst) begin
            for (int i = 0; i < DEPTH; i++) r_tbl[i] <= '0;
            r_err <= 1'b0;
        end else begin
            r_err <= i_wr_en && !w_ok;
            if (i_wr_en && w_ok) r_tbl[i_wr_addr] <= i_wr_ent;
        end
endmodule

// File: rtl/pwm_seq_ctrl.sv
// pwm_seq_ctrl: plays (cmp, top, rep) entries onto one PWM channel's config bus,
// advancing on period ends observed from the channel's cnt/top.
module pwm_seq_ctrl
    import pwm_seq_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int AW    = $clog2(DEPTH)
) (
    input logic           clk,
    input logic           nrst,
    pwm_seq_ctrl_if.slave bus
);
    state_t          r_state, w_state;
    logic [AW-1:0]   r_idx, w_idx;
    logic [AW:0]     r_len;
    logic            r_loop, r_first, r_done, r_err_st;
    logic [REPW-1:0] r_rep, r_rep_max;
    logic [1:0]      r_sel, w_sel;
    logic [15:0]     r_d, w_d;
    logic            w_done, w_err_st, w_err_wr, w_pend, w_last, w_start;
    pwm_entry_t      w_wr_ent, w_rd_ent;

    assign w_wr_ent = '{cmp: bus.wr_cmp, top: bus.wr_top, rep: bus.wr_rep};
    assign w_start  = r_state == IDLE && bus.start && !bus.stop;
    assign w_pend   = bus.pwm_cnt >= bus.pwm_top;
    assign w_last   = ({1'b0, r_rep} + 1'b1) >= {1'b0, r_rep_max};

    // Read port follows the next index so the registered bus carries the entry being entered
    pwm_seq_table #(.DEPTH(DEPTH), .AW(AW)) u_tbl (
        .clk       (clk),
        .nrst      (nrst),
        .i_wr_en   (bus.wr_en),
        .i_wr_addr (bus.wr_addr),
        .i_wr_ent  (w_wr_ent),
        .i_rd_addr (w_idx),
        .o_rd_ent  (w_rd_ent),
        .o_err     (w_err_wr)
    );

    always_comb begin
        w_state  = r_state;
        w_idx    = r_idx;
        w_done   = 1'b0;
        w_err_st = 1'b0;
        case (r_state)
            IDLE: if (w_start) begin
                w_err_st = bus.len == '0 || bus.len > (AW+1)'(DEPTH);
                w_state  = w_err_st ? IDLE : LD_CMP;
                w_idx    = w_err_st ? r_idx : '0;
            end
            LD_CMP: w_state = LD_TOP;
            LD_TOP: w_state = r_first ? SYNC : RUN;
            SYNC:   w_state = RUN;
            RUN: if (w_pend && w_last) begin
                if (({1'b0, r_idx} + 1'b1) < r_len) begin
                    w_state = LD_CMP;
                    w_idx   = r_idx + 1'b1;
                end else if (r_loop) begin
                    w_state = LD_CMP;
                    w_idx   = '0;
                end else begin
                    w_state = PARK;
                    w_done  = 1'b1;
                end
            end
            PARK:    w_state = IDLE;
            default: w_state = IDLE;
        endcase
        if (bus.stop && r_state != IDLE && r_state != PARK) begin
            w_state = PARK;
            w_idx   = r_idx;
            w_done  = 1'b0;
        end
        w_sel = (w_state == LD_CMP || w_state == PARK) ? SEL_CMP :
                w_state == LD_TOP ? SEL_TOP : w_state == SYNC ? SEL_CNT : SEL_NONE;
        w_d   = w_state == LD_CMP ? w_rd_ent.cmp : w_state == LD_TOP ? w_rd_ent.top : 16'd0;
    end

    always_ff @(posedge clk or negedge nrst)
        if (!nrst) begin
            r_state   <= IDLE;
            r_idx     <= '0;
            r_len     <= '0;
            r_loop    <= 1'b0;
            r_first   <= 1'b0;
            r_done    <= 1'b0;
            r_err_st  <= 1'b0;
            r_rep     <= '0;
            r_rep_max <= '0;
            r_sel     <= SEL_NONE;
            r_d       <= '0;
        end else begin
            r_state  <= w_state;
            r_idx    <= w_idx;
            r_sel    <= w_sel;
            r_d      <= w_d;
            r_done   <= w_done;
            r_err_st <= w_err_st;
            if (r_state == IDLE) begin
                r_len   <= bus.len;
                r_loop  <= bus.loop;
                r_first <= 1'b1;
            end else if (r_state == LD_TOP) r_first <= 1'b0;
            if (w_state == LD_TOP) r_rep_max <= w_rd_ent.rep == '0 ? REPW'(1) : w_rd_ent.rep;
            r_rep <= (r_state != RUN || (w_pend && w_last)) ? '0 : r_rep + REPW'(w_pend);
        end

    assign bus.pwm_sel = r_sel;
    assign bus.pwm_d   = r_d;
    assign bus.busy    = r_state != IDLE;
    assign bus.idx     = r_idx;
    assign bus.done    = r_done;
    assign bus.err     = r_err_st | w_err_wr;
endmodule

// File: tb/tb_pwm_seq_ctrl.sv
// tb_pwm_seq_ctrl: drives random tables through the sequencer against a PWM channel model
// and scores every channel write, period count, idx and done against an expected write list.
module tb_pwm_seq_ctrl;
    import pwm_seq_pkg::*;
    localparam int DEPTH = 8;
    typedef struct {int sel; int d; int idx; int ends; bit dn;} exp_t;

    logic        clk = 1'b0;
    logic        nrst = 1'b0;
    logic [15:0] ch_cnt = 16'd0;
    logic [15:0] ch_top = 16'd5;
    int          total = 0;
    int          bad = 0;
    int          ends = 0;
    int          n;
    exp_t        exp_q[$];
    exp_t        m_e;
    int          m_cmp[DEPTH];
    int          m_top[DEPTH];
    int          m_rep[DEPTH];

    pwm_seq_ctrl_if #(.DEPTH(DEPTH)) bus();
    pwm_seq_ctrl #(.DEPTH(DEPTH)) dut (.clk(clk), .nrst(nrst), .bus(bus));

    always #5 clk = ~clk;

    // Channel: free-running up counter wrapping after top; sel writes top or cnt
    assign bus.pwm_cnt = ch_cnt;
    assign bus.pwm_top = ch_top;
    always @(posedge clk) begin
        if (bus.pwm_sel == SEL_TOP) ch_top <= bus.pwm_d;
        if (bus.pwm_sel == SEL_CNT) ch_cnt <= bus.pwm_d;
        else ch_cnt <= (ch_cnt >= ch_top) ? 16'd0 : ch_cnt + 16'd1;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    function automatic int rmax(input int r);
        return r == 0 ? 1 : r;
    endfunction

    always @(negedge clk) if (nrst) begin
        if (bus.pwm_sel != SEL_NONE) begin
            if (exp_q.size() == 0) chk("extra_wr", {bus.pwm_sel, bus.pwm_d}, 0);
            else begin
                m_e = exp_q.pop_front();
                chk("wr", {bus.pwm_sel, bus.pwm_d}, m_e.sel * 65536 + m_e.d);
                if (m_e.idx >= 0) chk("idx", bus.idx, m_e.idx);
                if (m_e.ends >= 0) chk("periods", ends, m_e.ends);
                chk("done", bus.done, m_e.dn);
                if (bus.pwm_sel == SEL_CMP) ends = 0;
            end
        end else begin
            if (bus.done) chk("done_stray", bus.done, 0);
            if (bus.busy && bus.pwm_cnt >= bus.pwm_top) ends++;
        end
    end

    task automatic wr(input int a, input int c, input int t, input int r);
        bus.wr_en = 1'b1;
        bus.wr_addr = 3'(a);
        bus.wr_cmp = 16'(c);
        bus.wr_top = 16'(t);
        bus.wr_rep = 8'(r);
        tick();
        bus.wr_en = 1'b0;
        chk("err_wr", bus.err, t < 2);
        if (t >= 2) begin
            m_cmp[a] = c;
            m_top[a] = t;
            m_rep[a] = r;
        end
    endtask

    task automatic clear_model();
        for (int a = 0; a < DEPTH; a++) begin
            m_cmp[a] = 0;
            m_top[a] = 0;
            m_rep[a] = 0;
        end
    endtask

    task automatic fill(input int len, input bit lp, input int loads);
        exp_q.delete();
        for (int k = 0; k < loads; k++) begin
            int e = k % len;
            int p = (k + len - 1) % len;
            exp_q.push_back('{1, m_cmp[e], e, k == 0 ? -1 : rmax(m_rep[p]), 1'b0});
            exp_q.push_back('{2, m_top[e], e, -1, 1'b0});
            if (k == 0) exp_q.push_back('{3, 0, -1, -1, 1'b0});
        end
        if (!lp) exp_q.push_back('{1, 0, -1, rmax(m_rep[len-1]), 1'b1});
        bus.len = 4'(len);
        bus.loop = lp;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        for (int c = 0; c < 3000 && exp_q.size() != 0; c++) tick();
        chk("drain", exp_q.size(), 0);
    endtask

    task automatic play(input int len, input bit lp, input int loads, input bit with_start);
        fill(len, lp, loads);
        if (lp) begin
            tick();
            chk("run_sel", bus.pwm_sel, 0);
            exp_q.push_back('{1, 0, -1, -1, 1'b0});
            bus.stop = 1'b1;
            bus.start = with_start;
            tick();
            bus.stop = 1'b0;
            bus.start = 1'b0;
            chk("park", exp_q.size(), 0);
        end
        tick();
        chk("idle", bus.busy, 0);
    endtask

    initial begin
        bus.wr_en = 1'b0;
        bus.wr_addr = '0;
        bus.wr_cmp = '0;
        bus.wr_top = '0;
        bus.wr_rep = '0;
        bus.len = '0;
        bus.loop = 1'b0;
        bus.start = 1'b0;
        bus.stop = 1'b0;
        clear_model();
        repeat (2) tick();
        chk("rst_sel", bus.pwm_sel, 0);
        chk("rst_d", bus.pwm_d, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_idx", bus.idx, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_err", bus.err, 0);
        nrst = 1'b1;
        tick();
        play(1, 1'b0, 1, 1'b0);
        wr(0, 3, 9, 2);
        play(1, 1'b0, 1, 1'b0);
        wr(0, 17, 6, 0);
        wr(1, 40, 4, 3);
        play(2, 1'b1, 5, 1'b0);
        wr(1, 99, 1, 5);
        play(2, 1'b0, 2, 1'b0);
        bus.len = 4'd0;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        chk("err_len0", bus.err, 1);
        chk("busy_len0", bus.busy, 0);
        bus.len = 4'(DEPTH + 1);
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        chk("err_len_big", bus.err, 1);
        chk("busy_len_big", bus.busy, 0);
        repeat (6) begin
            for (int a = 0; a < DEPTH; a++)
                wr(a, $urandom_range(0, 65535), $urandom_range(0, 12), $urandom_range(0, 3));
            n = $urandom_range(1, DEPTH);
            play(n, 1'b0, n, 1'b0);
        end
        n = $urandom_range(2, DEPTH);
        play(n, 1'b1, n + 3, 1'b1);
        wr(0, 5, 3, 1);
        wr(1, 7, 40, 3);
        fill(2, 1'b1, 2);
        repeat (3) tick();
        chk("run_busy", bus.busy, 1);
        chk("run_idx", bus.idx, 1);
        nrst = 1'b0;
        #1;
        chk("arst_sel", bus.pwm_sel, 0);
        chk("arst_d", bus.pwm_d, 0);
        chk("arst_busy", bus.busy, 0);
        chk("arst_idx", bus.idx, 0);
        exp_q.delete();
        clear_model();
        tick();
        nrst = 1'b1;
        tick();
        wr(0, 11, 5, 2);
        wr(1, 22, 3, 0);
        play(2, 1'b0, 2, 1'b0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/pwm_seq_ctrl.md
Name: pwm_seq_ctrl

Overview:
Sequencer that drives the configuration bus (d/sel) of a 16-bit PWM channel from a small table of (cmp, top, repeat) entries.
- Plays the table entry by entry, holding each entry for `rep` PWM periods.
- Detects period boundaries by observing the channel's cnt/top outputs.
- Optionally loops, and parks the channel with duty 0 on stop or completion.
- Sits between the CPU-side register interface and one PWM channel.

Parameters:
- DEPTH, 8, number of table entries.
- AW, $clog2(DEPTH), table index width.
- REPW, 8, repeat-count width.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- nrst  in  1  asynchronous active-low reset.
- wr_en  in  1  table write strobe.
- wr_addr  in  AW  table entry index.
- wr_cmp  in  16  entry compare value.
- wr_top  in  16  entry period top value.
- wr_rep  in  REPW  periods per entry; 0 is treated as 1.
- len  in  AW+1  number of entries to play, sampled on start.
- loop  in  1  restart at entry 0 after the last entry; sampled on start.
- start  in  1  begin playback (single-cycle pulse).
- stop  in  1  abort playback (single-cycle pulse).
- pwm_cnt  in  16  channel counter value.
- pwm_top  in  16  channel top value.
- pwm_d  out  16  channel data bus.
- pwm_sel  out  2  channel select: 0 idle, 1 cmp, 2 top, 3 cnt.
- busy  out  1  high in every state except IDLE.
- idx  out  AW  entry currently playing.
- done  out  1  one-cycle pulse on normal completion.
- err  out  1  one-cycle pulse on a rejected write or rejected start.

Behaviour:
Reset:
- State IDLE.
- pwm_sel=0, pwm_d=0, busy=0, idx=0, done=0, err=0.
- Table cleared to all zeros; repeat counter 0.

Channel bus:
- pwm_sel/pwm_d are registered and at most one write is issued per cycle.
- pwm_sel=0 in every cycle not listed below.

Table writes:
- Accepted in any state when wr_top >= 2.
- wr_top < 2 → write dropped, err pulses next cycle.
- A write to an entry while busy takes effect the next time that entry is loaded.

Start:
- Ignored unless IDLE.
- len==0 or len>DEPTH → err pulse, remain IDLE.
- Otherwise latch len and loop, set idx=0, enter LD_CMP.

States:
- LD_CMP: sel=1, d=tbl[idx].cmp.
  - Next state: LD_TOP.
- LD_TOP: sel=2, d=tbl[idx].top.
  - Next state: SYNC if this is the first load after start, else RUN.
- SYNC: sel=3, d=0 (restart the period cleanly).
  - Next state: RUN.
- RUN: a period end occurs in each cycle where pwm_cnt >= pwm_top.
  - Not last repeat: rep counter +1.
  - Last repeat (counter+1 >= max(rep,1)): counter cleared.
    - idx < len-1 → idx+1, go to LD_CMP.
    - idx == len-1 and loop=1 → idx=0, go to LD_CMP (no SYNC).
    - idx == len-1 and loop=0 → go to PARK.
  - The new entry is therefore written during cycles 1–2 of the following period; top >= 2 guarantees the counter has not already passed the new top.
- PARK: sel=1, d=0 (output low).
  - Came from completion → done pulses this cycle.
  - Next state: IDLE.

Stop:
- In any busy state → PARK on the next edge, no done pulse.
- Stop and start in the same cycle → stop wins; start ignored.

Other:
- Repeat counter width is REPW; it never wraps because it is compared against rep before incrementing.
- Reset asserted mid-operation → immediate return to the reset values; the channel keeps its last written values.

Decomposition:
- Package pwm_seq_pkg holds:
  - state enum {IDLE, LD_CMP, LD_TOP, SYNC, RUN, PARK};
  - sel constants SEL_NONE=0, SEL_CMP=1, SEL_TOP=2, SEL_CNT=3;
  - packed struct pwm_entry_t {cmp[16], top[16], rep[REPW]}.
- Sub-module pwm_seq_table: DEPTH×pwm_entry_t register file with async clear, one write port and one combinational read port, plus the top>=2 check and err generation.

Test Plan:
- Reset → sel=0, d=0, busy=0; all table reads return 0.
- Write entry0 (cmp=3, top=9, rep=2), len=1, loop=0, start → sel sequence 1/3, 2/9, 3/0; after 2 observed period ends, PARK writes sel=1 d=0; done pulses; busy falls the next cycle.
- Entries 0 and 1 with len=2, loop=1 → idx runs 0,1,0,1; loads after the first carry no SYNC write; rep=0 behaves as rep=1.
- Write with wr_top=1 → err pulse, entry unchanged. Start with len=0 or len=DEPTH+1 → err pulse, busy stays 0.
- stop during RUN, and stop+start in the same cycle → PARK (sel=1, d=0) then IDLE; no done pulse.
- nrst asserted mid-RUN → outputs return to reset values immediately without a clock edge; a fresh start replays from idx 0.
